// File: rtl/text_cursor_writer.sv
// -----------------------------------------------------------------------------
// text_cursor_writer
//
// Purpose: accepts a stream of character codes and turns them into writes on
// a character-plane write port while tracking a text cursor. Printable codes
// are written at the cursor, which then advances. Newline, carriage return,
// backspace and form feed move the cursor. Running past the last row scrolls
// the plane with push_up and then blanks the new bottom row. All outputs are
// registered.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   char_in[7:0]   in   incoming character code
//   char_valid     in   char_in valid (source holds it until accepted)
//   char_ready     out  block accepts char_in this cycle (IDLE only)
//   wr_data[7:0]   out  character id to the plane write port
//   wr_row[3:0]    out  plane write row
//   wr_col[5:0]    out  plane write column
//   wr_en          out  plane write strobe
//   push_up        out  one-cycle scroll pulse
//   plane_clear    out  one-cycle full-plane clear pulse
//   cursor_row     out  current cursor row
//   cursor_col     out  current cursor column
//   cursor_visible out  cursor display enable
//
// Build option: define CURSOR_BLINK_EN to make cursor_visible blink every
// BLINK_PERIOD cycles. It is held on for BLINK_PERIOD cycles after each
// accepted character. When the macro is undefined, cursor_visible is
// constant 1.
// -----------------------------------------------------------------------------
module text_cursor_writer #(
  parameter int ROW_NUMBER   = 15,
  parameter int COL_NUMBER   = 40,
  parameter int BLINK_PERIOD = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] wr_data,
  output logic [3:0] wr_row,
  output logic [5:0] wr_col,
  output logic       wr_en,
  output logic       push_up,
  output logic       plane_clear,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col,
  output logic       cursor_visible
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    SCROLL    = 3'd2,
    CLEAR_ROW = 3'd3,
    CLEAR_ALL = 3'd4
  } state_t;

  localparam logic [3:0] ROW_LAST = 4'(ROW_NUMBER - 1);
  localparam logic [5:0] COL_LAST = 6'(COL_NUMBER - 1);

  // Elaboration-time sanity check: the geometry must fit the port widths.
  if (ROW_NUMBER < 1 || ROW_NUMBER > 16 || COL_NUMBER < 1 || COL_NUMBER > 64 ||
      BLINK_PERIOD < 1) begin : g_param_check
    $error("text_cursor_writer: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [3:0] cursor_row_q, cursor_row_d;
  logic [5:0] cursor_col_q, cursor_col_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [3:0] wr_row_q, wr_row_d;
  logic [5:0] wr_col_q, wr_col_d;
  logic       wr_en_q, wr_en_d;
  logic       push_up_q, push_up_d;
  logic       plane_clear_q, plane_clear_d;
  logic       char_ready_q, char_ready_d;
  // A printable written at the very last cell must scroll once the write is done.
  logic       scroll_pend_q, scroll_pend_d;
  logic       accept_s;

  assign accept_s = char_valid && char_ready_q;

  // Next-state and next-output logic. The outputs are registered, so each
  // branch sets up the values for the state being entered.
  always_comb begin
    state_d       = state_q;
    cursor_row_d  = cursor_row_q;
    cursor_col_d  = cursor_col_q;
    wr_data_d     = wr_data_q;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    wr_en_d       = 1'b0;
    push_up_d     = 1'b0;
    plane_clear_d = 1'b0;
    scroll_pend_d = scroll_pend_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_data_d = char_in;
            wr_row_d  = cursor_row_q;
            wr_col_d  = cursor_col_q;
            if (cursor_col_q < COL_LAST) begin
              cursor_col_d = cursor_col_q + 6'd1;
            end else if (cursor_row_q < ROW_LAST) begin
              cursor_row_d = cursor_row_q + 4'd1;
              cursor_col_d = 6'd0;
            end else begin
              cursor_col_d  = 6'd0;
              scroll_pend_d = 1'b1;
            end
          end else begin
            case (char_in)
              8'h0A: begin
                cursor_col_d = 6'd0;
                if (cursor_row_q < ROW_LAST) begin
                  cursor_row_d = cursor_row_q + 4'd1;
                end else begin
                  state_d   = SCROLL;
                  push_up_d = 1'b1;
                end
              end
              8'h0D: begin
                cursor_col_d = 6'd0;
              end
              8'h08: begin
                // Erase the cell left of the cursor, wrapping to the previous row.
                if (cursor_col_q != 6'd0) begin
                  state_d      = WRITE;
                  wr_en_d      = 1'b1;
                  wr_data_d    = 8'h00;
                  wr_row_d     = cursor_row_q;
                  wr_col_d     = cursor_col_q - 6'd1;
                  cursor_col_d = cursor_col_q - 6'd1;
                end else if (cursor_row_q != 4'd0) begin
                  state_d      = WRITE;
                  wr_en_d      = 1'b1;
                  wr_data_d    = 8'h00;
                  wr_row_d     = cursor_row_q - 4'd1;
                  wr_col_d     = COL_LAST;
                  cursor_row_d = cursor_row_q - 4'd1;
                  cursor_col_d = COL_LAST;
                end else begin
                  state_d = IDLE;
                end
              end
              8'h0C: begin
                state_d       = CLEAR_ALL;
                plane_clear_d = 1'b1;
                cursor_row_d  = 4'd0;
                cursor_col_d  = 6'd0;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (scroll_pend_q) begin
          state_d       = SCROLL;
          push_up_d     = 1'b1;
          scroll_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SCROLL: begin
        state_d   = CLEAR_ROW;
        wr_en_d   = 1'b1;
        wr_data_d = 8'h00;
        wr_row_d  = ROW_LAST;
        wr_col_d  = 6'd0;
      end
      CLEAR_ROW: begin
        // wr_col_q holds the column written in this cycle.
        if (wr_col_q == COL_LAST) begin
          state_d = IDLE;
        end else begin
          wr_en_d  = 1'b1;
          wr_col_d = wr_col_q + 6'd1;
        end
      end
      CLEAR_ALL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    char_ready_d = (state_d == IDLE);
  end

  // State, cursor and output registers. Reset abandons any sequence in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cursor_row_q  <= 4'd0;
      cursor_col_q  <= 6'd0;
      wr_data_q     <= 8'h00;
      wr_row_q      <= 4'd0;
      wr_col_q      <= 6'd0;
      wr_en_q       <= 1'b0;
      push_up_q     <= 1'b0;
      plane_clear_q <= 1'b0;
      char_ready_q  <= 1'b0;
      scroll_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_row_q  <= cursor_row_d;
      cursor_col_q  <= cursor_col_d;
      wr_data_q     <= wr_data_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_en_q       <= wr_en_d;
      push_up_q     <= push_up_d;
      plane_clear_q <= plane_clear_d;
      char_ready_q  <= char_ready_d;
      scroll_pend_q <= scroll_pend_d;
    end
  end

  assign char_ready  = char_ready_q;
  assign wr_data     = wr_data_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_en       = wr_en_q;
  assign push_up     = push_up_q;
  assign plane_clear = plane_clear_q;
  assign cursor_row  = cursor_row_q;
  assign cursor_col  = cursor_col_q;

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_PERIOD + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          cursor_visible_q, cursor_visible_d;

  // Blink timer: an accepted character restarts the period with the cursor shown.
  always_comb begin
    blink_cnt_d      = blink_cnt_q;
    cursor_visible_d = cursor_visible_q;
    if (accept_s) begin
      blink_cnt_d      = {BW{1'b0}};
      cursor_visible_d = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
      blink_cnt_d      = {BW{1'b0}};
      cursor_visible_d = ~cursor_visible_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  // Blink registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q      <= {BW{1'b0}};
      cursor_visible_q <= 1'b1;
    end else begin
      blink_cnt_q      <= blink_cnt_d;
      cursor_visible_q <= cursor_visible_d;
    end
  end

  assign cursor_visible = cursor_visible_q;
`else
  assign cursor_visible = 1'b1;
`endif

endmodule

// File: tb/tb_text_cursor_writer.sv
// -----------------------------------------------------------------------------
// tb_text_cursor_writer
//
// Self-checking bench for text_cursor_writer. The reference model keeps the
// cursor and a queue of the outputs expected in upcoming cycles. Each
// accepted character appends its whole output sequence to that queue. The
// block is ready exactly when the current cycle takes nothing from the
// queue. A negedge process compares every output on every cycle. Directed
// scenarios add hand-computed literal checks, and a randomized phase
// follows. Blink expectations follow CURSOR_BLINK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_text_cursor_writer;

  localparam int ROWS = 15;
  localparam int COLS = 40;
  localparam int BP   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] wr_data;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic       wr_en, push_up, plane_clear;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       cursor_visible;

  text_cursor_writer #(.ROW_NUMBER(ROWS), .COL_NUMBER(COLS), .BLINK_PERIOD(BP)) dut (
    .clock(clock), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_data(wr_data), .wr_row(wr_row), .wr_col(wr_col),
    .wr_en(wr_en), .push_up(push_up), .plane_clear(plane_clear),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_visible(cursor_visible)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic       pu;
    logic       pc;
    logic [7:0] d;
    logic [3:0] r;
    logic [5:0] c;
  } cyc_t;

  cyc_t       plan_q[$];
  int         m_row, m_col, m_t;
  logic       e_we, e_pu, e_pc, e_rdy;
  logic [7:0] e_d;
  logic [3:0] e_r;
  logic [5:0] e_c;
  logic       chk_en = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic we, input logic pu, input logic pc,
                              input logic [7:0] d, input int r, input int c);
    cyc_t x;
    x.we = we; x.pu = pu; x.pc = pc; x.d = d; x.r = 4'(r); x.c = 6'(c);
    return x;
  endfunction

  task automatic push_scroll();
    plan_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 0, 0));
    for (int i = 0; i < COLS; i++) plan_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, ROWS - 1, i));
  endtask

  // Turns one accepted character into a cursor move and the output cycles that follow.
  task automatic plan(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      plan_q.push_back(mk(1'b1, 1'b0, 1'b0, ch, m_row, m_col));
      if (m_col < COLS - 1) m_col++;
      else if (m_row < ROWS - 1) begin m_row++; m_col = 0; end
      else begin m_col = 0; push_scroll(); end
    end else if (ch == 8'h0A) begin
      m_col = 0;
      if (m_row < ROWS - 1) m_row++;
      else push_scroll();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--; plan_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, m_row, m_col));
      end else if (m_row > 0) begin
        m_row--; m_col = COLS - 1; plan_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, m_row, m_col));
      end
    end else if (ch == 8'h0C) begin
      plan_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 0, 0));
      m_row = 0; m_col = 0;
    end
  endtask

  // Advances the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    cyc_t x;
    if (reset) begin
      plan_q.delete();
      m_row = 0; m_col = 0; m_t = 0;
      e_we = 1'b0; e_pu = 1'b0; e_pc = 1'b0; e_rdy = 1'b0;
      e_d = 8'h00; e_r = 4'd0; e_c = 6'd0;
    end else begin
      if (char_valid && e_rdy) begin
        m_t = 0;
        plan(char_in);
      end else begin
        m_t++;
      end
      e_we = 1'b0; e_pu = 1'b0; e_pc = 1'b0;
      if (plan_q.size() > 0) begin
        x = plan_q.pop_front();
        e_we = x.we; e_pu = x.pu; e_pc = x.pc;
        if (x.we) begin e_d = x.d; e_r = x.r; e_c = x.c; end
        e_rdy = 1'b0;
      end else begin
        e_rdy = 1'b1;
      end
    end
  endtask

  function automatic logic exp_vis();
`ifdef CURSOR_BLINK_EN
    return ((m_t / BP) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("wr_en", 32'(wr_en), 32'(e_we));
      check("push_up", 32'(push_up), 32'(e_pu));
      check("plane_clear", 32'(plane_clear), 32'(e_pc));
      check("char_ready", 32'(char_ready), 32'(e_rdy));
      check("wr_data", 32'(wr_data), 32'(e_d));
      check("wr_row", 32'(wr_row), 32'(e_r));
      check("wr_col", 32'(wr_col), 32'(e_c));
      check("cursor_row", 32'(cursor_row), 32'(m_row));
      check("cursor_col", 32'(cursor_col), 32'(m_col));
      check("cursor_visible", 32'(cursor_visible), 32'(exp_vis()));
    end
  end

  task automatic tick();
    @(posedge clock);
    model_edge();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; char_valid = 1'b0;
    tick(); tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_char_ready", 32'(char_ready), 32'd0);
    check("rst_cursor", {22'd0, cursor_row, cursor_col}, 32'd0);
    check("rst_visible", 32'(cursor_visible), 32'd1);
    reset = 1'b0;
  endtask

  // Waits (bounded) for the model to be ready, then presents ch for one accepting edge.
  task automatic send(input logic [7:0] ch);
    int n;
    n = 0;
    while (!e_rdy && n < 200) begin tick(); n++; end
    if (!e_rdy) check("send_timeout", 32'd1, 32'd0);
    char_in = ch; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] ch, input int n);
    for (int i = 0; i < n; i++) send(ch);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ch;
    int r;

    // First character after reset.
    do_reset();
    send(8'h41);
    check("A_wr_en", 32'(wr_en), 32'd1);
    check("A_wr_data", 32'(wr_data), 32'h41);
    check("A_wr_pos", {22'd0, wr_row, wr_col}, 32'd0);
    check("A_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd0, 6'd1});

    // Last column of a middle row wraps to the next row.
    send_n(8'h0A, 3);
    send_n(8'h61, 39);
    send(8'h42);
    check("wrap_wr_pos", {22'd0, wr_row, wr_col}, {22'd0, 4'd3, 6'd39});
    check("wrap_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd4, 6'd0});
    check("wrap_busy", 32'(char_ready), 32'd0);
    tick();
    check("wrap_ready", 32'(char_ready), 32'd1);

    // Newline on the last row: scroll, then blank the bottom row.
    send_n(8'h0A, 10);
    send_n(8'h30, 5);
    send(8'h0A);
    check("nl_push_up", 32'(push_up), 32'd1);
    check("nl_push_wr_en", 32'(wr_en), 32'd0);
    for (int i = 0; i < COLS; i++) begin
      tick();
      check("clr_wr", {16'd0, wr_en, wr_data, wr_row, wr_col}, {16'd0, 1'b1, 8'h00, 4'd14, 6'(i)});
    end
    tick();
    check("clr_done_wr_en", 32'(wr_en), 32'd0);
    check("clr_done_ready", 32'(char_ready), 32'd1);
    check("clr_done_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd14, 6'd0});

    // Backspace across a row boundary, then at the origin.
    do_reset();
    send_n(8'h0A, 2);
    send(8'h08);
    check("bs_wr", {16'd0, wr_en, wr_data, wr_row, wr_col}, {16'd0, 1'b1, 8'h00, 4'd1, 6'd39});
    check("bs_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd1, 6'd39});
    do_reset();
    send(8'h08);
    check("bs0_wr_en", 32'(wr_en), 32'd0);
    check("bs0_cursor", {22'd0, cursor_row, cursor_col}, 32'd0);

    // Reset during the 10th write of the row clear.
    do_reset();
    send_n(8'h0A, 14);
    send(8'h0A);
    for (int i = 0; i < 10; i++) tick();
    check("mid_clr_col", 32'(wr_col), 32'd9);
    reset = 1'b1;
    tick();
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_cursor", {22'd0, cursor_row, cursor_col}, 32'd0);
    check("abort_ready", 32'(char_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("abort_wr_en2", 32'(wr_en), 32'd0);
    check("abort_ready2", 32'(char_ready), 32'd1);

    // Form feed from the middle of the plane, then idle blink.
    send_n(8'h0A, 7);
    send_n(8'h7A, 20);
    check("pre_ff_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd7, 6'd20});
    send(8'h0C);
    check("ff_plane_clear", 32'(plane_clear), 32'd1);
    check("ff_wr_en", 32'(wr_en), 32'd0);
    check("ff_cursor", {22'd0, cursor_row, cursor_col}, 32'd0);
    check("ff_visible", 32'(cursor_visible), 32'd1);
    tick();
    check("ff_done", {30'd0, plane_clear, char_ready}, 32'd1);
    tick(); tick(); tick();
`ifdef CURSOR_BLINK_EN
    check("blink_off", 32'(cursor_visible), 32'd0);
`else
    check("blink_off", 32'(cursor_visible), 32'd1);
`endif
    tick(); tick(); tick(); tick();
    check("blink_on", 32'(cursor_visible), 32'd1);

    // Randomized traffic, including valid while busy and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      char_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 15);
      if (r <= 9) ch = 8'($urandom_range(32'h20, 32'h7E));
      else if (r == 10) ch = 8'h0A;
      else if (r == 11) ch = 8'h0D;
      else if (r == 12) ch = 8'h08;
      else if (r == 13) ch = ($urandom_range(0, 15) == 0) ? 8'h0C : 8'h5F;
      else if (r == 14) ch = 8'($urandom_range(0, 31));
      else ch = 8'($urandom_range(32'h7F, 32'hFF));
      char_in = ch;
      tick();
    end
    reset = 1'b0; char_valid = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
